led_sequencer: RTL
==================

// Module: led_sequencer
// PURPOSE
//  Controller that sequences the board's 8-LED bank through selectable animations.
//  Holds a prescaler that generates a step tick, an IDLE/RUN/HOLD run-control FSM,
//  and a pattern register that drives led[7:0]. Sits between top-level buttons/config and the LED pins.
// PARAMETERS
//  DELAY  22  prescaler width in bits; one step tick every 2**DELAY clocks (>=1)
// PORTS
//  clk    in   1  system clock, all logic on rising edge
//  rst_n  in   1  synchronous active-low reset
//  mode   in   2  animation select, sampled only on start from IDLE
//  start  in   1  single-cycle pulse: begin (IDLE) or resume (HOLD)
//  stop   in   1  single-cycle pulse: pause (RUN) or clear (HOLD)
//  busy   out  1  high in RUN or HOLD
//  tick   out  1  one-cycle step strobe (RUN only)
//  led    out  8  LED drive, active-high
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, led=8'h00, busy=0, tick=0, cnt=0, dir=LEFT.
//  Prescaler: cnt[DELAY-1:0] increments only in RUN; tick=1 on the cycle cnt is all-ones.
//   Cleared to 0 on IDLE->RUN; frozen (not cleared) in HOLD.
//  FSM (stop has priority when start & stop arrive in the same cycle):
//   IDLE: start -> RUN; latch mode into mode_q; load the init pattern; cnt=0.
//   RUN : stop -> HOLD; else advance the pattern on each tick.
//   HOLD: stop -> IDLE, led=0; start -> RUN, resume with the same mode_q/pattern/cnt.
//   Pulses not listed for a state are ignored; mode changes outside IDLE+start are ignored.
//  Latency:
//   - led shows the init pattern one edge after start is sampled.
//   - First step happens 2**DELAY clocks after entering RUN.
//   - Each later step happens every 2**DELAY RUN clocks.
//  Modes (init / step):
//   0 COUNT : 8'h00 / led+1, wraps 8'hFF->8'h00.
//   1 BOUNCE: 8'h01 / dir=LEFT: shift left. At 8'h80, dir<=RIGHT and the same step
//     shifts right, giving 8'h40. Mirrored at 8'h01. Period = 14 ticks.
//   2 BLINK : 8'hFF / ~led.
//   3 ROTATE: 8'h01 / rotate left, 8'h80->8'h01.
//   dir is reset to LEFT on every IDLE->RUN.
//  Reset mid-operation: overrides everything the same cycle and returns to the reset state.
//  busy is registered and changes on the same edge as the state.
// CONFIGURATION
//  LED_PWM_EN defined:
//   - Adds port brightness in 4 (sampled continuously).
//   - Adds a free-running 4-bit pwm_cnt (reset 0).
//   - led = pattern & {8{pwm_cnt < brightness}}.
//   - brightness=0 gives always dark; 15 gives 15/16 duty.
//   - busy, tick and FSM are unaffected.
//  LED_PWM_EN undefined: no brightness port, no pwm_cnt; led = pattern register directly.
// STRUCTURE
//  led_seq_defs.vh (shared include):
//   - MODE_COUNT=0, MODE_BOUNCE=1, MODE_BLINK=2, MODE_ROTATE=3.
//   - ST_IDLE=0, ST_RUN=1, ST_HOLD=2 (2-bit).
//   - DIR_LEFT=0, DIR_RIGHT=1.
//  Sub-module led_seq_prescaler #(DELAY):
//   - Ports: clk, rst_n, en, clr, tick.
//   - Holds cnt.
//  FSM, mode latch, pattern/dir registers and the optional PWM gate live in led_sequencer.
// TESTING (bench uses DELAY=2 -> tick every 4 RUN clocks)
//  1 Reset: hold rst_n=0 for 3 clk -> led=00, busy=0, tick=0; after release, no change without start.
//  2 COUNT: mode=0, start -> led=00, busy=1.
//    Then 00,01,02... one step per 4 clk.
//    Preload check: 256 steps wrap back to 00.
//  3 BOUNCE: mode=1, start -> 01,02,04..80,40,20..01,02.
//    Check that 80 and 01 each appear once per sweep.
//  4 Pause: in ROTATE at led=04, stop -> HOLD.
//    led stays 04, tick=0 for 20 clk.
//    start -> next step to 08 arrives after the remaining prescaler count.
//    Then stop, stop -> IDLE, led=00, busy=0.
//  5 Priority/ignore:
//    - start & stop same cycle in RUN -> HOLD.
//    - mode change during RUN -> pattern is unaffected.
//    - stop in IDLE -> no change.
//  6 Reset mid-run: BLINK running (led=FF), rst_n=0 one cycle -> next edge led=00, IDLE, cnt=0.
//    With LED_PWM_EN:
//    - brightness=0 -> led=00 always.
//    - brightness=8 -> pattern visible exactly 8 of every 16 clk.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// rtl/led_sequencer_pkg.sv - shared mode/state/direction encodings and pattern step helpers
package led_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_ROTATE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        dir_e       dir;
        logic [7:0] pattern;
    } step_t;

    function automatic logic [7:0] init_pattern(input mode_e m);
        logic [7:0] p;
        case (m)
            MODE_COUNT:  p = 8'h00;
            MODE_BOUNCE: p = 8'h01;
            MODE_BLINK:  p = 8'hFF;
            MODE_ROTATE: p = 8'h01;
            default:     p = 8'h00;
        endcase
        return p;
    endfunction

    // Bounce reverses and moves in the same step, so the end LEDs are shown for one tick only.
    function automatic step_t next_step(input mode_e m, input logic [7:0] p, input dir_e d);
        step_t r;
        r.dir     = d;
        r.pattern = p;
        case (m)
            MODE_COUNT:  r.pattern = p + 8'd1;
            MODE_BOUNCE: begin
                if (d == DIR_LEFT) begin
                    if (p == 8'h80) begin
                        r.dir     = DIR_RIGHT;
                        r.pattern = p >> 1;
                    end else begin
                        r.pattern = p << 1;
                    end
                end else begin
                    if (p == 8'h01) begin
                        r.dir     = DIR_LEFT;
                        r.pattern = p << 1;
                    end else begin
                        r.pattern = p >> 1;
                    end
                end
            end
            MODE_BLINK:  r.pattern = ~p;
            MODE_ROTATE: r.pattern = {p[6:0], p[7]};
            default:     r.pattern = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// rtl/led_seq_prescaler.sv - step-tick prescaler, one tick every 2**DELAY enabled clocks
module led_seq_prescaler #(
    parameter int DELAY = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DELAY-1:0] cnt_q;
    logic [DELAY-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DELAY'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & (&cnt_q);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - 8-LED animation sequencer with IDLE/RUN/HOLD control.
// Optional LED_PWM_EN adds a brightness input gating the LEDs with a 16-step PWM.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int DELAY = 22
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef LED_PWM_EN
    input  logic [3:0] brightness,
`endif
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       tick,
    output logic [7:0] led
);

    state_e     state_q, state_d;
    logic       busy_q, busy_d;
    mode_e      mode_q, mode_d;
    logic [7:0] pattern_q, pattern_d;
    dir_e       dir_q, dir_d;
    step_t      step_nxt;
    logic       presc_en;
    logic       presc_clr;
    logic       presc_tick;

    // The counter idles at zero so every IDLE->RUN starts a full step period.
    assign presc_en  = (state_q == ST_RUN);
    assign presc_clr = (state_q == ST_IDLE);

    led_seq_prescaler #(
        .DELAY(DELAY)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (presc_tick)
    );

    assign step_nxt = next_step(mode_q, pattern_q, dir_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && !stop) state_d = ST_RUN;
            ST_RUN:  if (stop) state_d = ST_HOLD;
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        mode_d    = mode_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    mode_d    = mode_e'(mode);
                    pattern_d = init_pattern(mode_e'(mode));
                    dir_d     = DIR_LEFT;
                end
            end
            ST_RUN: begin
                if (!stop && presc_tick) begin
                    pattern_d = step_nxt.pattern;
                    dir_d     = step_nxt.dir;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    pattern_d = 8'h00;
                end
            end
            default: pattern_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_COUNT;
            pattern_q <= 8'h00;
            dir_q     <= DIR_LEFT;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
        end
    end

    assign busy = busy_q;
    assign tick = presc_tick;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;
    logic [3:0] pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign led = pattern_q & {8{pwm_cnt_q < brightness}};
`else
    assign led = pattern_q;
`endif

endmodule
